writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//   Final pipeline stage, directly upstream of the register file. Accepts ALU results and load
//   requests from execute, waits for load data, aligns and extends it, and issues one write
//   (RD, RD_data, we) per retired instruction. Never issues writes to x0. Times out stalled loads.
// PARAMETERS
//   WIDTH       32  datapath width
//   REG_ADDR_W  5   register index width
//   MEM_TIMEOUT 15  max WAIT_MEM cycles before load error; 0 = timeout disabled
// PORTS
//   iClk        in   1           clock, all state updates on posedge
//   iRstN       in   1           asynchronous, active-low reset
//   iEx_valid   in   1           execute presents a retiring instruction
//   oEx_ready   out  1           stage can accept (transfer = iEx_valid & oEx_ready)
//   iEx_rd      in   REG_ADDR_W  destination register
//   iEx_result  in   WIDTH       ALU result; for loads, byte address (bits [1:0] used)
//   iEx_is_load in   1           instruction is a load
//   iEx_funct3  in   3           load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   iMem_valid  in   1           load data valid (single-cycle pulse)
//   iMem_rdata  in   WIDTH       aligned 32-bit word containing the load target
//   oRD         out  REG_ADDR_W  register-file write index
//   oRD_data    out  WIDTH       register-file write data
//   oRD_we      out  1           register-file write enable, one cycle per commit
//   oLoadErr    out  1           one-cycle pulse: load timed out, no write issued
// BEHAVIOUR
//   Reset: state IDLE, timer 0, all outputs 0 except oEx_ready=1 after release. Asserted in any
//     state (incl. WAIT_MEM) abandons the instruction; no write issued after release.
//   States: IDLE, WAIT_MEM, COMMIT. oEx_ready=1 in IDLE and COMMIT, 0 in WAIT_MEM.
//   IDLE/COMMIT on transfer: non-load -> latch rd, result -> COMMIT. Load -> latch rd, funct3,
//     addr[1:0], clear timer -> WAIT_MEM. No transfer -> IDLE.
//   WAIT_MEM: iMem_valid -> extract, latch data -> COMMIT. Else timer++; when timer reaches
//     MEM_TIMEOUT-1 without iMem_valid -> oLoadErr=1 for one cycle, -> IDLE, no write.
//     iMem_valid and timeout in same cycle: data wins, no error.
//   COMMIT: oRD_we = (oRD != 0) for exactly this cycle; oRD/oRD_data valid; held until next commit.
//   Latency: ALU op accepted cycle N -> oRD_we at N+1; load data at cycle M -> oRD_we at M+1.
//   Throughput: back-to-back ALU ops commit every cycle (COMMIT accepts next op).
//   iMem_valid outside WAIT_MEM is ignored.
//   Extraction: LB/LBU byte lane addr[1:0]; LH/LHU half addr[1]; addr[0] ignored for halves,
//     addr[1:0] ignored for LW. LB/LH sign-extend, LBU/LHU zero-extend. funct3 011/110/111 = LW.
// CONFIGURATION
//   WB_FWD_EN defined: extra ports oFwd_valid(1), oFwd_rd(REG_ADDR_W), oFwd_data(WIDTH), equal
//     to oRD_we/oRD/oRD_data in the commit cycle; decode bypasses same-cycle regfile reads.
//   WB_FWD_EN undefined: ports and logic absent; decode must stall on RAW to committing rd.
// STRUCTURE
//   Package wb_pkg: state enum, funct3 load encodings (LB..LHU), default WIDTH/REG_ADDR_W.
//   Sub-module load_extract: combinational lane select + sign/zero extension (funct3, addr, word).
//   Timer width $clog2(MEM_TIMEOUT+1); whole timer logic omitted when MEM_TIMEOUT == 0.
// TESTING
//   ALU op rd=5, result 0xDEADBEEF at cycle N -> N+1: oRD_we=1, oRD=5, oRD_data=0xDEADBEEF.
//   LB addr=2, mem 0x12F45678 -> oRD_data=0xFFFFFFF4; LBU same -> 0x000000F4.
//   LH addr=2, mem 0x80011234 -> 0xFFFF8001; LHU -> 0x00008001; LW -> 0x80011234.
//   ALU op rd=0, result 0x1 -> oRD_we stays 0 for all cycles; oEx_ready stays 1.
//   MEM_TIMEOUT=4, load with no iMem_valid -> oLoadErr pulses once, no oRD_we, oEx_ready=1 next.
//   3 consecutive ALU transfers -> 3 consecutive oRD_we pulses; iRstN low in WAIT_MEM, then
//     iMem_valid after release -> no oRD_we, outputs 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states, load
// funct3 encodings, default datapath widths and the pending-load context.
package wb_pkg;

    localparam int unsigned WB_WIDTH      = 32;
    localparam int unsigned WB_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Everything needed to shape load data once it arrives.
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] addr;
    } load_ctx_t;

endpackage

// File: rtl/load_extract.sv
// Combinational load data shaping: picks the byte/half lane from an aligned
// word and sign- or zero-extends it. Unknown funct3 codes behave as LW.
// Ports: funct3 (load type), addr (byte offset), word (aligned memory word),
//        data_c (extended result).
module load_extract
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = WB_WIDTH
)(
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select; addr[0] is irrelevant for halves.
    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = word[{addr[1], 4'b0000} +: 16];
    end

    always_comb begin
        data_c = word;
        case (funct3)
            F3_LB:   data_c = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_c = {{(WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data_c = {{(WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_c = {{(WIDTH-16){1'b0}}, half_sel};
            default: data_c = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results and loads into the register file,
// one write per instruction, never to x0, with a stalled-load timeout.
// Optional feature macro WB_FWD_EN adds same-cycle forwarding ports.
// Ports:
//   iClk/iRstN                       clock, async active-low reset
//   iEx_valid/oEx_ready              execute handshake
//   iEx_rd/iEx_result/iEx_is_load/iEx_funct3  retiring instruction
//   iMem_valid/iMem_rdata            load return data
//   oRD/oRD_data/oRD_we              register-file write port
//   oFwd_valid/oFwd_rd/oFwd_data     forwarding copy (WB_FWD_EN only)
//   oLoadErr                         load timeout pulse
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH       = WB_WIDTH,
    parameter int unsigned REG_ADDR_W  = WB_REG_ADDR_W,
    parameter int unsigned MEM_TIMEOUT = 15
)(
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iEx_valid,
    output logic                  oEx_ready,
    input  logic [REG_ADDR_W-1:0] iEx_rd,
    input  logic [WIDTH-1:0]      iEx_result,
    input  logic                  iEx_is_load,
    input  logic [2:0]            iEx_funct3,
    input  logic                  iMem_valid,
    input  logic [WIDTH-1:0]      iMem_rdata,
    output logic [REG_ADDR_W-1:0] oRD,
    output logic [WIDTH-1:0]      oRD_data,
    output logic                  oRD_we,
`ifdef WB_FWD_EN
    output logic                  oFwd_valid,
    output logic [REG_ADDR_W-1:0] oFwd_rd,
    output logic [WIDTH-1:0]      oFwd_data,
`endif
    output logic                  oLoadErr
);

    localparam int unsigned TMR_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

    wb_state_e             state_q, state_d;
    logic                  ready_q, ready_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
    load_ctx_t             ctx_q, ctx_d;

    logic                  xfer_c;
    logic                  load_xfer_c;
    logic                  timeout_c;
    logic [WIDTH-1:0]      ext_c;

    // ready_q is only high in IDLE/COMMIT, so it alone qualifies a transfer.
    assign xfer_c      = iEx_valid & ready_q;
    assign load_xfer_c = xfer_c & iEx_is_load;

    load_extract #(.WIDTH(WIDTH)) u_extract (
        .funct3 (ctx_q.funct3),
        .addr   (ctx_q.addr),
        .word   (iMem_rdata),
        .data_c (ext_c)
    );

    // Stall timer: counts WAIT_MEM cycles without data.
    generate
        if (MEM_TIMEOUT != 0) begin : g_timer
            logic [TMR_W-1:0] timer_q;

            always_ff @(posedge iClk or negedge iRstN) begin
                if (!iRstN) begin
                    timer_q <= '0;
                end else if (load_xfer_c) begin
                    timer_q <= '0;
                end else if (state_q == ST_WAIT_MEM && !iMem_valid) begin
                    timer_q <= timer_q + TMR_W'(1);
                end
            end

            // Data arriving on the final cycle wins over the timeout.
            assign timeout_c = (state_q == ST_WAIT_MEM) && !iMem_valid &&
                               (timer_q == TMR_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timer
            assign timeout_c = 1'b0;
        end
    endgenerate

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        data_d    = data_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        pend_rd_d = pend_rd_q;
        ctx_d     = ctx_q;

        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                state_d = ST_IDLE;
                if (xfer_c) begin
                    if (iEx_is_load) begin
                        pend_rd_d    = iEx_rd;
                        ctx_d.funct3 = iEx_funct3;
                        ctx_d.addr   = iEx_result[1:0];
                        state_d      = ST_WAIT_MEM;
                    end else begin
                        rd_d    = iEx_rd;
                        data_d  = iEx_result;
                        we_d    = (iEx_rd != '0);
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (iMem_valid) begin
                    rd_d    = pend_rd_q;
                    data_d  = ext_c;
                    we_d    = (pend_rd_q != '0);
                    state_d = ST_COMMIT;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d != ST_WAIT_MEM);
    end

    // State and output registers.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            pend_rd_q <= '0;
            ctx_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            we_q      <= we_d;
            err_q     <= err_d;
            pend_rd_q <= pend_rd_d;
            ctx_q     <= ctx_d;
        end
    end

    assign oEx_ready = ready_q;
    assign oRD       = rd_q;
    assign oRD_data  = data_q;
    assign oRD_we    = we_q;
    assign oLoadErr  = err_q;

`ifdef WB_FWD_EN
    assign oFwd_valid = we_q;
    assign oFwd_rd    = rd_q;
    assign oFwd_data  = data_q;
`endif

endmodule
